// File: rtl/axis_frame_gen_if.sv
// AXI-stream master/slave bundle for the frame generator output.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI-stream frame source: cfg_count frames of cfg_len bytes, incrementing byte pattern,
// with abort truncation (tuser) and per-frame completion pulses.
module axis_frame_gen_lane #(
  parameter int LANE      = 0,
  parameter int LEN_WIDTH = 16
) (
  input  logic [7:0]           base,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [7:0]           lane_byte,
  output logic                 lane_keep
);
  assign lane_keep = LEN_WIDTH'(LANE) < remaining;
  assign lane_byte = lane_keep ? base + 8'(LANE) : 8'h00;
endmodule

module axis_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [15:0]           cfg_count,
  input  logic [7:0]            cfg_seed,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  axis_frame_gen_if.master      m_axis,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_d;

  logic [LEN_WIDTH-1:0]  len_q, byte_off;
  logic [15:0]           count_q, frame_idx;
  logic [7:0]            seed_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  gen_done, abort_pend;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tvalid_q, tlast_q, tuser_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic [DEST_WIDTH-1:0] tdest_q;

  // In IDLE the first beat is built straight from cfg_* so it lands on the start edge.
  logic                  idle;
  logic [LEN_WIDTH-1:0]  gen_len, remaining;
  logic [7:0]            gen_seed, gen_base;
  logic [ID_WIDTH-1:0]   gen_id;
  logic [DEST_WIDTH-1:0] gen_dest;
  logic                  beat_last, last_frame, abort_eff;

  assign idle       = (state == IDLE);
  assign gen_len    = idle ? cfg_len  : len_q;
  assign gen_seed   = idle ? cfg_seed : seed_q;
  assign gen_id     = idle ? cfg_id   : id_q;
  assign gen_dest   = idle ? cfg_dest : dest_q;
  assign remaining  = gen_len - byte_off;
  assign gen_base   = gen_seed + frame_idx[7:0] + 8'(byte_off);
  assign beat_last  = remaining <= LEN_WIDTH'(KEEP_WIDTH);
  assign last_frame = idle ? (cfg_count == 16'd1) : (frame_idx == count_q - 16'd1);
  assign abort_eff  = abort | abort_pend;

  logic [KEEP_WIDTH-1:0][7:0] lane_byte;
  logic [KEEP_WIDTH-1:0]      lane_keep;

  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    axis_frame_gen_lane #(.LANE(i), .LEN_WIDTH(LEN_WIDTH)) u_lane (
      .base      (gen_base),
      .remaining (remaining),
      .lane_byte (lane_byte[i]),
      .lane_keep (lane_keep[i])
    );
  end

  logic load, finish, abort_beat, pend_set, done_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    finish     = 1'b0;
    abort_beat = 1'b0;
    pend_set   = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: if (start && cfg_len != '0 && cfg_count != '0) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: begin
        if (tvalid_q && m_axis.tready && tlast_q) begin
          done_pulse = 1'b1;
          // An abort landing on a tlast beat lets that frame end cleanly, then stops.
          if (gen_done || abort_eff) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            load = 1'b1;
          end
        end else if (!tvalid_q || m_axis.tready) begin
          load       = !gen_done;
          abort_beat = abort_eff && !gen_done;
        end else if (abort) begin
          pend_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0; count_q <= '0; seed_q <= '0; id_q <= '0; dest_q <= '0;
      byte_off <= '0; frame_idx <= '0; gen_done <= 1'b0; abort_pend <= 1'b0;
      tdata_q <= '0; tkeep_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0; tuser_q <= 1'b0;
      tid_q <= '0; tdest_q <= '0;
      frame_done <= 1'b0; frames_sent <= '0;
    end else begin
      frame_done <= done_pulse;
      if (done_pulse) frames_sent <= frames_sent + 16'd1;
      if (pend_set) abort_pend <= 1'b1;
      if (idle && load) begin
        len_q <= cfg_len; count_q <= cfg_count; seed_q <= cfg_seed;
        id_q <= cfg_id; dest_q <= cfg_dest;
      end
      if (load) begin
        tdata_q  <= lane_byte;
        tkeep_q  <= lane_keep;
        tvalid_q <= 1'b1;
        tlast_q  <= beat_last | abort_beat;
        tuser_q  <= abort_beat;
        tid_q    <= gen_id;
        tdest_q  <= gen_dest;
        gen_done <= abort_beat | (beat_last & last_frame);
        if (abort_beat) abort_pend <= 1'b0;
        if (beat_last) begin
          byte_off  <= '0;
          frame_idx <= frame_idx + 16'd1;
        end else begin
          byte_off <= byte_off + LEN_WIDTH'(KEEP_WIDTH);
        end
      end else if (finish) begin
        tdata_q <= '0; tkeep_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0; tuser_q <= 1'b0;
        tid_q <= '0; tdest_q <= '0;
        byte_off <= '0; frame_idx <= '0; gen_done <= 1'b0; abort_pend <= 1'b0;
      end
    end
  end

  assign busy          = (state == RUN);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = KEEP_ENABLE ? tkeep_q : '1;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tid    = tid_q;
  assign m_axis.tdest  = tdest_q;
endmodule
